control_unit: RTL and testbench
===============================

# control_unit

Instruction sequencer for the 16-bit accumulator CPU. Sits directly upstream of the datapath: issues the fetch pulse, waits for the instruction register to settle, decodes the opcode, sequences indirect addressing, and holds one control line plus the execute qualifier until the datapath reports completion. It also counts retired instructions and flags protocol errors and timeouts.

## Interface
Parameters:
- IR_WAIT, 3: cycles from the o_fetch pulse to the i_ir sample (1..7).
- IND_WAIT, 2: cycles from the o_is_ind pulse to entry into EXEC (1..7).
- TIMEOUT, 15: maximum EXEC cycles without i_ex_done (2..15).

Ports:
- clk  in  1  clock, rising edge
- i_clr_reg  in  1  reset, asynchronous, active-high
- i_run  in  1  start/restart request, sampled in IDLE and HALT only
- i_ir  in  16  instruction register from the datapath
- i_decoding  in  1  datapath decoding flag
- i_ex_done  in  1  datapath execute-complete flag
- o_fetch  out  1  one-cycle fetch pulse
- o_execute  out  1  execute qualifier
- o_is_ind  out  1  one-cycle indirect-address load pulse
- o_is_dir  out  1  effective address valid, memory-reference execute
- o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  out  1 each  register-reference operations
- o_add, o_load, o_store, o_branch, o_isz  out  1 each  memory-reference operations
- o_busy  out  1  state is not IDLE and not HALT
- o_halt  out  1  halted by the HLT instruction or by an error
- o_err  out  1  sticky error flag
- o_icount  out  16  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, IND, EXEC, HALT. Reset enters IDLE and clears every output, counter and latched IR to 0.
- IDLE/HALT: i_run=1 → FETCH and o_halt clears. o_err clears only on reset. i_run is ignored in all other states.
- FETCH: lasts one cycle with o_fetch=1, then → DECODE.
- DECODE: counts IR_WAIT cycles, then latches i_ir into an internal register.
  - If i_decoding=0 at the latch, set o_err and → HALT.
- Decode of the latched IR: I=IR[15], op=IR[14:12].
  - op 0..4 map to add, load, store, branch, isz.
  - op 5 and op 6 are illegal: set o_err, → HALT, no count.
  - op 7 with I=1 is HLT: o_icount+1, → HALT.
  - op 7 with I=0 is a register reference. The active line is selected by priority, highest bit first: bit11 clr_ac, bit10 clr_e, bit9 comp_ac, bit8 load_ac, bit7 cir_r, bit6 cir_l, bit5 inc_ac. Only the single highest set bit is issued; the other bits are ignored.
    - If bit8 is selected, IR[7:0] is immediate data, so lower bits are never examined.
    - If no bit in IR[11:5] is set, the instruction is a NOP: o_icount+1, → FETCH with no EXEC.
- Memory reference with I=1: → IND with o_is_ind=1 for one cycle. Wait IND_WAIT cycles, then → EXEC.
- Memory reference with I=0: → EXEC directly.
- EXEC: o_execute and the selected op line are held high. o_is_dir=1 for memory-reference instructions and 0 for register-reference instructions.
  - i_ex_done is ignored in the first EXEC cycle.
  - When i_ex_done=1 is sampled: o_icount+1 (wraps FFFF→0000), → FETCH.
  - If TIMEOUT EXEC cycles elapse with no i_ex_done: set o_err, → HALT, no count.
- All control outputs are registered. At most one op line is high at any time, and op lines are high only in EXEC.

## Timing
- Outputs are registered and valid one cycle after the state transition.
- Fetch edge f to i_ir sample: IR_WAIT cycles. The first EXEC cycle is f+IR_WAIT+1 for direct instructions and f+IR_WAIT+1+IND_WAIT+1 for indirect ones.
- i_ex_done sampled at EXEC cycle k (k≥2): op lines drop and o_fetch rises on the next cycle. There is no idle gap between instructions.
- Asynchronous reset mid-instruction: all outputs are 0 immediately; on release the block sits in IDLE until i_run.
- i_ex_done and timeout expiry in the same cycle: done wins, no error.

## Test plan
- Reset, then i_run. Latched IR 0x1005 (direct load); assert i_ex_done in EXEC cycle 2 → o_load, o_execute and o_is_dir high for exactly 2 cycles; o_icount=1; o_fetch pulses again on the next cycle.
- IR 0x8003 (indirect add) → one o_is_ind pulse; o_add begins IND_WAIT+1 cycles later with o_is_dir=1.
- IR 0x7FE0 → only o_clr_ac asserted. IR 0x7000 → no EXEC, o_icount increments, immediate refetch.
- IR 0x5000 → o_err=1, o_halt=1, o_icount unchanged. i_run → o_halt clears and o_err stays 1.
- i_ex_done never asserted → o_err set after 15 EXEC cycles. Preload o_icount near 0xFFFF, retire two instructions → o_icount=0x0001 (wrap).
- Assert i_clr_reg during EXEC → all outputs 0 within the same cycle; no activity until i_run.

Source files
------------

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle of signals between the instruction sequencer and the
//                datapath. The sequencer uses the master modport. The datapath
//                side, or a bench standing in for it, uses the slave modport.
//  Signals     : i_run, i_ir[15:0], i_decoding, i_ex_done   (into sequencer)
//                o_fetch, o_execute, o_is_ind, o_is_dir, register-reference
//                op lines, memory-reference op lines, o_busy, o_halt, o_err,
//                o_icount[15:0]                            (out of sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
    logic        i_run;
    logic [15:0] i_ir;
    logic        i_decoding;
    logic        i_ex_done;

    logic        o_fetch;
    logic        o_execute;
    logic        o_is_ind;
    logic        o_is_dir;
    logic        o_clr_ac;
    logic        o_clr_e;
    logic        o_comp_ac;
    logic        o_load_ac;
    logic        o_cir_r;
    logic        o_cir_l;
    logic        o_inc_ac;
    logic        o_add;
    logic        o_load;
    logic        o_store;
    logic        o_branch;
    logic        o_isz;
    logic        o_busy;
    logic        o_halt;
    logic        o_err;
    logic [15:0] o_icount;

    modport master (
        input  i_run, i_ir, i_decoding, i_ex_done,
        output o_fetch, o_execute, o_is_ind, o_is_dir,
               o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
               o_add, o_load, o_store, o_branch, o_isz,
               o_busy, o_halt, o_err, o_icount
    );

    modport slave (
        output i_run, i_ir, i_decoding, i_ex_done,
        input  o_fetch, o_execute, o_is_ind, o_is_dir,
               o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
               o_add, o_load, o_store, o_branch, o_isz,
               o_busy, o_halt, o_err, o_icount
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Instruction sequencer for the 16-bit accumulator CPU. It
//                issues the fetch pulse and waits IR_WAIT cycles for the
//                instruction register. It then decodes the opcode and
//                sequences indirect addressing. It holds a single op line
//                together with o_execute until the datapath reports done.
//                It also counts retired instructions and flags protocol
//                errors and execute timeouts.
//  Ports       : clk        rising-edge clock
//                i_clr_reg  asynchronous active-high reset
//                bus        control_unit_if.master (handshake, IR, op lines,
//                           status and retired-instruction count)
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter int IR_WAIT  = 3,
    parameter int IND_WAIT = 2,
    parameter int TIMEOUT  = 15
) (
    input  wire            clk,
    input  wire            i_clr_reg,
    control_unit_if.master bus
);
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_ind    = 3'd3;
    localparam logic [2:0] c_st_exec   = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    // The cycle counter restarts at 0 on entry to FETCH, IND and EXEC. It
    // keeps running from FETCH into DECODE, so in FETCH/DECODE it holds the
    // number of cycles since the fetch edge.
    localparam logic [3:0] c_ir_latch = 4'(IR_WAIT - 1);
    localparam logic [3:0] c_ir_done  = 4'(IR_WAIT);
    localparam logic [3:0] c_ind_done = 4'(IND_WAIT);
    localparam logic [3:0] c_tmo_last = 4'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_ir;
    logic        r_dec_bad;
    logic        r_err;
    logic [15:0] r_icount;
    logic        w_set_err;
    logic        w_retire;
    logic        w_latch;

    // Decode of the latched instruction
    logic        w_ind;
    logic [2:0]  w_op;
    logic        w_mem;
    logic        w_illegal;
    logic        w_hlt;
    logic        w_rref;
    logic        w_nop;
    logic [6:0]  w_rsel;   // [6]=clr_ac .. [0]=inc_ac

    assign w_ind     = r_ir[15];
    assign w_op      = r_ir[14:12];
    assign w_mem     = (w_op < 3'd5);
    assign w_illegal = (w_op == 3'd5) || (w_op == 3'd6);
    assign w_hlt     = (w_op == 3'd7) && w_ind;
    assign w_rref    = (w_op == 3'd7) && !w_ind;
    assign w_nop     = w_rref && (r_ir[11:5] == 7'd0);

    // The highest set bit wins. Once load_ac (bit 8) is chosen, IR[7:0] is
    // immediate data, and the priority chain never reaches those bits.
    always_comb begin
        w_rsel = 7'd0;
        if      (r_ir[11]) w_rsel[6] = 1'b1;
        else if (r_ir[10]) w_rsel[5] = 1'b1;
        else if (r_ir[9])  w_rsel[4] = 1'b1;
        else if (r_ir[8])  w_rsel[3] = 1'b1;
        else if (r_ir[7])  w_rsel[2] = 1'b1;
        else if (r_ir[6])  w_rsel[1] = 1'b1;
        else if (r_ir[5])  w_rsel[0] = 1'b1;
    end

    assign w_latch = ((r_state == c_st_fetch) || (r_state == c_st_decode)) &&
                     (r_cnt == c_ir_latch);

    // ---------------- state register and datapath registers ----------------
    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_ir      <= 16'd0;
            r_dec_bad <= 1'b0;
            r_err     <= 1'b0;
            r_icount  <= 16'd0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) && (w_next != c_st_decode))
                r_cnt <= 4'd0;
            else
                r_cnt <= r_cnt + 4'd1;
            if (w_latch) begin
                r_ir      <= bus.i_ir;
                r_dec_bad <= ~bus.i_decoding;
            end
            if (w_set_err)
                r_err <= 1'b1;
            if (w_retire)
                r_icount <= r_icount + 16'd1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            c_st_idle, c_st_halt: begin
                if (bus.i_run)
                    w_next = c_st_fetch;
            end
            c_st_fetch: begin
                w_next = c_st_decode;
            end
            c_st_decode: begin
                // One cycle after the IR sample, act on the latched copy.
                if (r_cnt == c_ir_done) begin
                    if (r_dec_bad || w_illegal) begin
                        w_next    = c_st_halt;
                        w_set_err = 1'b1;
                    end else if (w_hlt) begin
                        w_next   = c_st_halt;
                        w_retire = 1'b1;
                    end else if (w_nop) begin
                        w_next   = c_st_fetch;
                        w_retire = 1'b1;
                    end else if (w_mem && w_ind) begin
                        w_next = c_st_ind;
                    end else begin
                        w_next = c_st_exec;
                    end
                end
            end
            c_st_ind: begin
                if (r_cnt == c_ind_done)
                    w_next = c_st_exec;
            end
            c_st_exec: begin
                // Done is ignored in the first EXEC cycle. If done arrives in
                // the same cycle as expiry, done takes priority.
                if ((r_cnt != 4'd0) && bus.i_ex_done) begin
                    w_next   = c_st_fetch;
                    w_retire = 1'b1;
                end else if (r_cnt == c_tmo_last) begin
                    w_next    = c_st_halt;
                    w_set_err = 1'b1;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // ---------------- output logic (registered from next state) ----------------
    logic       w_fetch, w_execute, w_is_ind, w_is_dir, w_busy, w_halt;
    logic [4:0] w_mem_ops;   // [4]=add [3]=load [2]=store [1]=branch [0]=isz
    logic [6:0] w_reg_ops;
    logic       r_fetch, r_execute, r_is_ind, r_is_dir, r_busy, r_halt;
    logic [4:0] r_mem_ops;
    logic [6:0] r_reg_ops;

    always_comb begin
        w_fetch   = (w_next == c_st_fetch);
        w_execute = (w_next == c_st_exec);
        w_is_ind  = (w_next == c_st_ind) && (r_state != c_st_ind);
        w_is_dir  = w_execute && w_mem;
        w_busy    = (w_next != c_st_idle) && (w_next != c_st_halt);
        w_halt    = (w_next == c_st_halt);
        w_mem_ops = 5'd0;
        w_reg_ops = 7'd0;
        if (w_execute && w_mem)
            w_mem_ops = 5'b10000 >> w_op;
        if (w_execute && w_rref)
            w_reg_ops = w_rsel;
    end

    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            r_fetch   <= 1'b0;
            r_execute <= 1'b0;
            r_is_ind  <= 1'b0;
            r_is_dir  <= 1'b0;
            r_busy    <= 1'b0;
            r_halt    <= 1'b0;
            r_mem_ops <= 5'd0;
            r_reg_ops <= 7'd0;
        end else begin
            r_fetch   <= w_fetch;
            r_execute <= w_execute;
            r_is_ind  <= w_is_ind;
            r_is_dir  <= w_is_dir;
            r_busy    <= w_busy;
            r_halt    <= w_halt;
            r_mem_ops <= w_mem_ops;
            r_reg_ops <= w_reg_ops;
        end
    end

    assign bus.o_fetch   = r_fetch;
    assign bus.o_execute = r_execute;
    assign bus.o_is_ind  = r_is_ind;
    assign bus.o_is_dir  = r_is_dir;
    assign bus.o_busy    = r_busy;
    assign bus.o_halt    = r_halt;
    assign bus.o_err     = r_err;
    assign bus.o_icount  = r_icount;
    assign bus.o_add     = r_mem_ops[4];
    assign bus.o_load    = r_mem_ops[3];
    assign bus.o_store   = r_mem_ops[2];
    assign bus.o_branch  = r_mem_ops[1];
    assign bus.o_isz     = r_mem_ops[0];
    assign bus.o_clr_ac  = r_reg_ops[6];
    assign bus.o_clr_e   = r_reg_ops[5];
    assign bus.o_comp_ac = r_reg_ops[4];
    assign bus.o_load_ac = r_reg_ops[3];
    assign bus.o_cir_r   = r_reg_ops[2];
    assign bus.o_cir_l   = r_reg_ops[1];
    assign bus.o_inc_ac  = r_reg_ops[0];
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed self-checking bench for control_unit. It drives
//                hand-picked instruction words and compares the sequencer
//                outputs against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;
    logic clk;
    logic i_clr_reg;
    int   n_checks;
    int   n_fails;

    control_unit_if bus();

    control_unit #(
        .IR_WAIT (3),
        .IND_WAIT(2),
        .TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .i_clr_reg(i_clr_reg),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {add,load,store,branch,isz,clr_ac,clr_e,comp_ac,load_ac,cir_r,cir_l,inc_ac}
    wire [11:0] w_ops = {bus.o_add, bus.o_load, bus.o_store, bus.o_branch, bus.o_isz,
                         bus.o_clr_ac, bus.o_clr_e, bus.o_comp_ac, bus.o_load_ac,
                         bus.o_cir_r, bus.o_cir_l, bus.o_inc_ac};
    wire [34:0] w_all = {bus.o_fetch, bus.o_execute, bus.o_is_ind, bus.o_is_dir, w_ops,
                         bus.o_busy, bus.o_halt, bus.o_err, bus.o_icount};

    localparam int c_sel_fetch = 0;
    localparam int c_sel_exec  = 1;
    localparam int c_sel_ind   = 2;
    localparam int c_sel_halt  = 3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            c_sel_fetch: return bus.o_fetch;
            c_sel_exec:  return bus.o_execute;
            c_sel_ind:   return bus.o_is_ind;
            default:     return bus.o_halt;
        endcase
    endfunction

    // Steps until the selected output is high. n is the number of cycles taken,
    // or -1 if the bound expires. It also counts execute and is_ind cycles
    // seen on the way.
    task automatic wait_for(input int sel, output int n, output int exec_cyc,
                            output int ind_cyc);
        n = -1;
        exec_cyc = 0;
        ind_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.o_execute) exec_cyc++;
            if (bus.o_is_ind) ind_cyc++;
            if (pick(sel)) begin
                n = k;
                break;
            end
        end
    endtask

    // Raise done in EXEC cycle 1, where it is ignored. It is sampled at the end
    // of cycle 2. This leaves the DUT in the following FETCH cycle.
    task automatic finish_exec();
        bus.i_ex_done = 1'b1;
        step();
        step();
        bus.i_ex_done = 1'b0;
    endtask

    task automatic test_reset();
        i_clr_reg = 1'b1;
        #1;
        n_checks++;
        if (w_all !== 35'd0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h expected 0", w_all);
        end
        step();
        step();
        i_clr_reg = 1'b0;
        step();
        step();
        n_checks++;
        if (w_all !== 35'd0) begin
            n_fails++;
            $display("FAIL reset_idle_no_run: got %h expected 0", w_all);
        end
    endtask

    task automatic test_direct_load();
        int n, ec, ic;
        bus.i_ir = 16'h1005;
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        n_checks++;
        if (bus.o_fetch !== 1'b1 || bus.o_busy !== 1'b1) begin
            n_fails++;
            $display("FAIL first_fetch: got fetch=%b busy=%b expected 1 1", bus.o_fetch, bus.o_busy);
        end
        wait_for(c_sel_exec, n, ec, ic);
        n_checks++;
        if (n !== 4) begin
            n_fails++;
            $display("FAIL load_exec_latency: got %0d expected 4", n);
        end
        n_checks++;
        if (w_ops !== 12'h400 || bus.o_is_dir !== 1'b1) begin
            n_fails++;
            $display("FAIL load_ops: got ops=%h dir=%b expected 400 1", w_ops, bus.o_is_dir);
        end
        bus.i_ex_done = 1'b1;
        step();
        n_checks++;
        if (bus.o_execute !== 1'b1 || w_ops !== 12'h400) begin
            n_fails++;
            $display("FAIL load_exec_cycle2: got exec=%b ops=%h expected 1 400", bus.o_execute, w_ops);
        end
        step();
        bus.i_ex_done = 1'b0;
        n_checks++;
        if (bus.o_fetch !== 1'b1 || bus.o_execute !== 1'b0 || w_ops !== 12'h000) begin
            n_fails++;
            $display("FAIL load_refetch: got fetch=%b exec=%b ops=%h expected 1 0 000",
                     bus.o_fetch, bus.o_execute, w_ops);
        end
        n_checks++;
        if (bus.o_icount !== 16'd1) begin
            n_fails++;
            $display("FAIL load_icount: got %h expected 0001", bus.o_icount);
        end
    endtask

    task automatic test_indirect_add();
        int n, ec, ic;
        bus.i_ir = 16'h8003;
        wait_for(c_sel_ind, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_execute !== 1'b0) begin
            n_fails++;
            $display("FAIL ind_pulse_latency: got n=%0d exec=%b expected 4 0", n, bus.o_execute);
        end
        wait_for(c_sel_exec, n, ec, ic);
        n_checks++;
        if (n !== 3 || ic !== 0) begin
            n_fails++;
            $display("FAIL ind_to_exec: got n=%0d extra_ind=%0d expected 3 0", n, ic);
        end
        n_checks++;
        if (w_ops !== 12'h800 || bus.o_is_dir !== 1'b1) begin
            n_fails++;
            $display("FAIL add_ops: got ops=%h dir=%b expected 800 1", w_ops, bus.o_is_dir);
        end
        finish_exec();
        n_checks++;
        if (bus.o_fetch !== 1'b1 || bus.o_icount !== 16'd2) begin
            n_fails++;
            $display("FAIL add_retire: got fetch=%b icount=%h expected 1 0002", bus.o_fetch, bus.o_icount);
        end
    endtask

    task automatic test_regref();
        logic [15:0] irs [5] = '{16'h7FE0, 16'h7120, 16'h7060, 16'h7020, 16'h7400};
        logic [11:0] exps[5] = '{12'h040, 12'h008, 12'h002, 12'h001, 12'h020};
        int n, ec, ic;
        for (int i = 0; i < 5; i++) begin
            bus.i_ir = irs[i];
            wait_for(c_sel_exec, n, ec, ic);
            n_checks++;
            if (n !== 4 || w_ops !== exps[i] || bus.o_is_dir !== 1'b0) begin
                n_fails++;
                $display("FAIL regref_%h: got n=%0d ops=%h dir=%b expected 4 %h 0",
                         irs[i], n, w_ops, bus.o_is_dir, exps[i]);
            end
            finish_exec();
            n_checks++;
            if (bus.o_icount !== 16'(3 + i)) begin
                n_fails++;
                $display("FAIL regref_icount_%0d: got %h expected %h", i, bus.o_icount, 16'(3 + i));
            end
        end
    endtask

    task automatic test_nop();
        int n, ec, ic;
        bus.i_ir = 16'h7000;
        wait_for(c_sel_fetch, n, ec, ic);
        n_checks++;
        if (n !== 4 || ec !== 0 || bus.o_icount !== 16'd8) begin
            n_fails++;
            $display("FAIL nop_refetch: got n=%0d exec_cycles=%0d icount=%h expected 4 0 0008",
                     n, ec, bus.o_icount);
        end
    endtask

    task automatic test_hlt();
        int n, ec, ic;
        bus.i_ir = 16'hF000;
        wait_for(c_sel_halt, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_err !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_icount !== 16'd9) begin
            n_fails++;
            $display("FAIL hlt: got n=%0d err=%b busy=%b icount=%h expected 4 0 0 0009",
                     n, bus.o_err, bus.o_busy, bus.o_icount);
        end
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        n_checks++;
        if (bus.o_fetch !== 1'b1 || bus.o_halt !== 1'b0) begin
            n_fails++;
            $display("FAIL hlt_restart: got fetch=%b halt=%b expected 1 0", bus.o_fetch, bus.o_halt);
        end
    endtask

    task automatic test_timeout();
        int n, ec, ic;
        bus.i_ir = 16'h2000;
        wait_for(c_sel_exec, n, ec, ic);
        n_checks++;
        if (n !== 4 || w_ops !== 12'h200) begin
            n_fails++;
            $display("FAIL store_exec: got n=%0d ops=%h expected 4 200", n, w_ops);
        end
        wait_for(c_sel_halt, n, ec, ic);
        n_checks++;
        if (n !== 15 || ec !== 14) begin
            n_fails++;
            $display("FAIL timeout_len: got n=%0d exec_cycles=%0d expected 15 14", n, ec);
        end
        n_checks++;
        if (bus.o_err !== 1'b1 || bus.o_icount !== 16'd9 || w_ops !== 12'h000) begin
            n_fails++;
            $display("FAIL timeout_err: got err=%b icount=%h ops=%h expected 1 0009 000",
                     bus.o_err, bus.o_icount, w_ops);
        end
    endtask

    task automatic test_wrap();
        int n, ec, ic;
        force dut.r_icount = 16'hFFFF;
        #1;
        release dut.r_icount;
        bus.i_ir = 16'h7000;
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        wait_for(c_sel_fetch, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_icount !== 16'h0000) begin
            n_fails++;
            $display("FAIL wrap_first: got n=%0d icount=%h expected 4 0000", n, bus.o_icount);
        end
        wait_for(c_sel_fetch, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_icount !== 16'h0001) begin
            n_fails++;
            $display("FAIL wrap_second: got n=%0d icount=%h expected 4 0001", n, bus.o_icount);
        end
    endtask

    task automatic test_async_reset();
        int n, ec, ic;
        bus.i_ir = 16'h0000;
        wait_for(c_sel_exec, n, ec, ic);
        n_checks++;
        if (n !== 4 || w_ops !== 12'h800) begin
            n_fails++;
            $display("FAIL pre_reset_exec: got n=%0d ops=%h expected 4 800", n, w_ops);
        end
        #2;
        i_clr_reg = 1'b1;
        #1;
        n_checks++;
        if (w_all !== 35'd0) begin
            n_fails++;
            $display("FAIL async_reset_clear: got %h expected 0", w_all);
        end
        step();
        i_clr_reg = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (w_all !== 35'd0) begin
            n_fails++;
            $display("FAIL post_reset_idle: got %h expected 0", w_all);
        end
    endtask

    task automatic test_illegal();
        int n, ec, ic;
        bus.i_ir = 16'h5000;
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        wait_for(c_sel_halt, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_err !== 1'b1 || bus.o_icount !== 16'd0 || ec !== 0) begin
            n_fails++;
            $display("FAIL illegal_op5: got n=%0d err=%b icount=%h exec=%0d expected 4 1 0000 0",
                     n, bus.o_err, bus.o_icount, ec);
        end
        bus.i_ir = 16'h6000;
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        n_checks++;
        if (bus.o_halt !== 1'b0 || bus.o_err !== 1'b1 || bus.o_fetch !== 1'b1) begin
            n_fails++;
            $display("FAIL illegal_restart: got halt=%b err=%b fetch=%b expected 0 1 1",
                     bus.o_halt, bus.o_err, bus.o_fetch);
        end
        wait_for(c_sel_halt, n, ec, ic);
        n_checks++;
        if (n !== 4 || bus.o_icount !== 16'd0) begin
            n_fails++;
            $display("FAIL illegal_op6: got n=%0d icount=%h expected 4 0000", n, bus.o_icount);
        end
    endtask

    task automatic test_decoding_err();
        int n, ec, ic;
        i_clr_reg = 1'b1;
        step();
        i_clr_reg = 1'b0;
        bus.i_decoding = 1'b0;
        bus.i_ir = 16'h1005;
        bus.i_run = 1'b1;
        step();
        bus.i_run = 1'b0;
        wait_for(c_sel_halt, n, ec, ic);
        bus.i_decoding = 1'b1;
        n_checks++;
        if (n < 1 || n > 4 || bus.o_err !== 1'b1 || ec !== 0 || bus.o_icount !== 16'd0) begin
            n_fails++;
            $display("FAIL decoding_err: got n=%0d err=%b exec=%0d icount=%h expected 1..4 1 0 0000",
                     n, bus.o_err, ec, bus.o_icount);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        bus.i_run = 1'b0;
        bus.i_ir = 16'h0000;
        bus.i_decoding = 1'b1;
        bus.i_ex_done = 1'b0;
        test_reset();
        test_direct_load();
        test_indirect_add();
        test_regref();
        test_nop();
        test_hlt();
        test_timeout();
        test_wrap();
        test_async_reset();
        test_illegal();
        test_decoding_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
